shift_arbiter: RTL and testbench

- Shares one BarrelShifter instance among R requesters.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Two-stage registered pipeline: operand register, then result register.
- Each result is tagged with the ID of the requester that issued it; sits between ALU front-end clients and the shared shift datapath.

---
 rtl/shift_arbiter_if.sv | 32 +++
 rtl/shift_arbiter.sv | 148 ++++++++++++++
 tb/tb_shift_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Requester/consumer bundle for the shared shifter arbiter.
// Requester k owns slice k of every packed per-requester vector.
interface shift_arbiter_if #(
  parameter int N = 32,
  parameter int R = 4
);
  localparam int SW = $clog2(N);
  localparam int IW = $clog2(R);

  logic [R-1:0]    req_valid;
  logic [R-1:0]    req_ready;
  logic [R*N-1:0]  req_input;
  logic [R*SW-1:0] req_shift_val;
  logic [R-1:0]    req_left_right;
  logic [R-1:0]    req_logic_arith;
  logic            resp_valid;
  logic            resp_ready;
  logic [N-1:0]    resp_result;
  logic [IW-1:0]   resp_id;

  // Requesters plus the result consumer.
  modport master (
    output req_valid, req_input, req_shift_val, req_left_right, req_logic_arith, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_id
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_input, req_shift_val, req_left_right, req_logic_arith, resp_ready,
    output req_ready, resp_valid, resp_result, resp_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among R requesters.
// Stage A holds the granted operand and feeds the combinational shifter;
// stage B registers the result and its requester ID toward the consumer.
module shift_arbiter #(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic             clk,
  input  logic             rst,
  shift_arbiter_if.slave   bus,
  output logic             busy_o
);
  localparam int SW = $clog2(N);
  localparam int IW = $clog2(R);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_t;

  // Per-requester views of the packed request fields
  logic [N-1:0]  req_op    [R];
  logic [SW-1:0] req_sh    [R];

  // Stage A
  logic          va_q;
  logic [N-1:0]  a_op_q;
  logic [SW-1:0] a_sh_q;
  logic          a_dir_q;
  logic          a_arith_q;
  logic [IW-1:0] a_id_q;

  // Stage B
  logic          vb_q;
  logic [N-1:0]  b_res_q;
  logic [IW-1:0] b_id_q;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  logic          load_b;
  logic          a_free;
  logic          found;
  logic          accept;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] idx;
  logic [R-1:0]  grant;
  logic          fill;
  logic [N-1:0]  shift_res;
  occ_t          occ;

  genvar gi;
  for (gi = 0; gi < R; gi++) begin : g_req
    assign req_op[gi] = bus.req_input[gi*N +: N];
    assign req_sh[gi] = bus.req_shift_val[gi*SW +: SW];
  end

  // B takes A's result whenever B is empty or being drained; A is reusable then too
  assign load_b = va_q & (~vb_q | bus.resp_ready);
  assign a_free = ~va_q | load_b;

  // Round-robin search starting at ptr_q; grant only when stage A can take it
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < R; i++) begin
      idx = ptr_q + IW'(i);
      if (!found && bus.req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found && a_free) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign accept        = found & a_free;
  assign bus.req_ready = grant;
  assign ptr_d         = accept ? grant_idx + 1'b1 : ptr_q;

  // Sign fill only for arithmetic right shifts of a negative operand
  assign fill = a_dir_q & a_arith_q & a_op_q[N-1];

  // Log-depth shifter: stage s moves the value by 2**s when bit s of the amount is set
  always_comb begin
    shift_res = a_op_q;
    for (int s = 0; s < SW; s++) begin
      if (a_sh_q[s]) begin
        if (a_dir_q) begin
          shift_res = (shift_res >> (1 << s)) |
                      (fill ? ~({N{1'b1}} >> (1 << s)) : {N{1'b0}});
        end else begin
          shift_res = shift_res << (1 << s);
        end
      end
    end
  end

  // Pipeline registers, pointer and stage valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_q      <= 1'b0;
      vb_q      <= 1'b0;
      a_op_q    <= '0;
      a_sh_q    <= '0;
      a_dir_q   <= 1'b0;
      a_arith_q <= 1'b0;
      a_id_q    <= '0;
      b_res_q   <= '0;
      b_id_q    <= '0;
      ptr_q     <= '0;
    end else begin
      if (accept) begin
        a_op_q    <= req_op[grant_idx];
        a_sh_q    <= req_sh[grant_idx];
        a_dir_q   <= bus.req_left_right[grant_idx];
        a_arith_q <= bus.req_logic_arith[grant_idx];
        a_id_q    <= grant_idx;
      end
      va_q <= accept | (va_q & ~load_b);
      if (load_b) begin
        b_res_q <= shift_res;
        b_id_q  <= a_id_q;
      end
      vb_q  <= load_b | (vb_q & ~bus.resp_ready);
      ptr_q <= ptr_d;
    end
  end

  // Occupancy view of the two stage valid bits
  always_comb begin
    occ = OCC_EMPTY;
    if (va_q && vb_q) begin
      occ = OCC_FULL;
    end else if (va_q || vb_q) begin
      occ = OCC_ONE;
    end
  end

  assign busy_o          = (occ != OCC_EMPTY);
  assign bus.resp_valid  = vb_q;
  assign bus.resp_result = b_res_q;
  assign bus.resp_id     = b_id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vector table plus streaming, backpressure,
// pointer and reset sequences, checked by a per-cycle model and a result scoreboard.
module tb_shift_arbiter;
  localparam int N  = 32;
  localparam int R  = 4;
  localparam int SW = $clog2(N);
  localparam int IW = $clog2(R);

  logic clk;
  logic rst;
  logic busy;

  shift_arbiter_if #(.N(N), .R(R)) bus ();

  shift_arbiter #(.N(N), .R(R)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           k;
    logic [N-1:0] op;
    int           sh;
    logic         dir;
    logic         ar;
    logic [N-1:0] exp;
  } vec_t;

  typedef struct {
    int           id;
    logic [N-1:0] res;
  } sb_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  sb_t          sb[$];
  int           acc_ids[$];
  logic [N-1:0] exp_res [R];

  // model state (monitor only)
  logic         mva, mvb;
  int           mptr;
  logic         hold_valid;
  logic [N-1:0] hold_res;
  logic [IW-1:0] hold_id;
  logic [R-1:0] exp_grant;
  logic         mload, mfree, mfound;
  int           mj;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] op, input int sh,
                                             input logic dir, input logic ar);
    if (!dir)     return op << sh;
    else if (ar)  return N'($signed(op) >>> sh);
    else          return op >> sh;
  endfunction

  task automatic set_req(input int k, input logic [N-1:0] op, input int sh,
                         input logic dir, input logic ar);
    bus.req_input[k*N +: N]       = op;
    bus.req_shift_val[k*SW +: SW] = SW'(sh);
    bus.req_left_right[k]         = dir;
    bus.req_logic_arith[k]        = ar;
    exp_res[k]                    = ref_shift(op, sh, dir, ar);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Cycle model + scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      mva = 1'b0; mvb = 1'b0; mptr = 0; hold_valid = 1'b0;
      sb.delete();
    end else begin
      chk("resp_valid", 64'(bus.resp_valid), 64'(mvb));
      chk("busy", 64'(busy), 64'(mva | mvb));
      if (hold_valid) begin
        chk("hold_result", 64'(bus.resp_result), 64'(hold_res));
        chk("hold_id", 64'(bus.resp_id), 64'(hold_id));
      end
      mload  = mva & (~mvb | bus.resp_ready);
      mfree  = ~mva | mload;
      exp_grant = '0;
      mfound = 1'b0;
      for (int i = 0; i < R; i++) begin
        mj = (mptr + i) % R;
        if (!mfound && bus.req_valid[mj]) begin
          mfound = 1'b1;
          if (mfree) exp_grant[mj] = 1'b1;
        end
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_grant));
      for (int k = 0; k < R; k++) begin
        if (bus.req_valid[k] && bus.req_ready[k]) begin
          sb.push_back('{id: k, res: exp_res[k]});
          acc_ids.push_back(k);
        end
        if (exp_grant[k]) mptr = (k + 1) % R;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(1), 64'(0));
        end else begin
          chk("resp_result", 64'(bus.resp_result), 64'(sb[0].res));
          chk("resp_id", 64'(bus.resp_id), 64'(sb[0].id));
          void'(sb.pop_front());
        end
      end
      hold_valid = bus.resp_valid & ~bus.resp_ready;
      hold_res   = bus.resp_result;
      hold_id    = bus.resp_id;
      mvb = mload | (mvb & ~bus.resp_ready);
      mva = (|exp_grant) | (mva & ~mload);
    end
  end

  vec_t vecs [9];
  int   base;
  logic got;

  initial begin
    vecs[0] = '{0, 32'h000000F0, 4,  1'b0, 1'b0, 32'h00000F00};
    vecs[1] = '{2, 32'h80000000, 31, 1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[2] = '{2, 32'h80000000, 31, 1'b1, 1'b0, 32'h00000001};
    vecs[3] = '{2, 32'h80000000, 0,  1'b1, 1'b1, 32'h80000000};
    vecs[4] = '{2, 32'h80000000, 0,  1'b0, 1'b1, 32'h80000000};
    vecs[5] = '{1, 32'h80000001, 1,  1'b0, 1'b1, 32'h00000002};
    vecs[6] = '{3, 32'hF0000000, 4,  1'b1, 1'b1, 32'hFF000000};
    vecs[7] = '{3, 32'h12345678, 8,  1'b1, 1'b0, 32'h00123456};
    vecs[8] = '{1, 32'h12345678, 16, 1'b0, 1'b0, 32'h56780000};

    rst = 1'b1;
    bus.req_valid = '0; bus.req_input = '0; bus.req_shift_val = '0;
    bus.req_left_right = '0; bus.req_logic_arith = '0; bus.resp_ready = 1'b1;
    for (int k = 0; k < R; k++) exp_res[k] = '0;
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_result", 64'(bus.resp_result), 64'(0));
    chk("rst_id", 64'(bus.resp_id), 64'(0));
    step(2);
    rst = 1'b0;
    step(1);

    // Directed vectors, one at a time; table expectation drives the scoreboard
    foreach (vecs[v]) begin
      set_req(vecs[v].k, vecs[v].op, vecs[v].sh, vecs[v].dir, vecs[v].ar);
      exp_res[vecs[v].k] = vecs[v].exp;
      bus.req_valid[vecs[v].k] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (bus.req_ready[vecs[v].k]) got = 1'b1;
      end
      chk("vec_accept_timeout", 64'(got), 64'(1));
      @(posedge clk); #1;           // accepting edge: operand in stage A
      bus.req_valid = '0;
      chk("vec_lat_a", 64'(bus.resp_valid), 64'(0));
      step(1);                      // next edge: result registered in stage B
      chk("vec_lat_b", 64'(bus.resp_valid), 64'(1));
      chk("vec_value", 64'(bus.resp_result), 64'(vecs[v].exp));
      step(2);
    end

    // All requesters streaming with the consumer always ready
    do_reset();
    for (int k = 0; k < R; k++) set_req(k, $urandom, $urandom_range(0, N-1), 1'($urandom), 1'($urandom));
    base = acc_ids.size();
    bus.req_valid = '1;
    step(12);
    bus.req_valid = '0;
    step(4);
    chk("stream_count", 64'(acc_ids.size() - base), 64'(12));
    for (int i = 0; i < 8; i++) chk("stream_order", 64'(acc_ids[base + i]), 64'(i % R));

    // Backpressure: only two accepts while the consumer stalls
    for (int k = 0; k < R; k++) set_req(k, $urandom, $urandom_range(0, N-1), 1'($urandom), 1'($urandom));
    base = acc_ids.size();
    bus.resp_ready = 1'b0;
    bus.req_valid  = '1;
    step(5);
    chk("bp_accepts", 64'(acc_ids.size() - base), 64'(2));
    chk("bp_ready_zero", 64'(bus.req_ready), 64'(0));
    bus.resp_ready = 1'b1;
    step(6);
    bus.req_valid = '0;
    step(4);
    chk("bp_drained", 64'(sb.size()), 64'(0));

    // Pointer at 2 with only requesters 1 and 3 valid
    do_reset();
    set_req(1, 32'h0000_00FF, 3, 1'b0, 1'b0);
    set_req(3, 32'hC000_0000, 2, 1'b1, 1'b1);
    bus.req_valid[1] = 1'b1;
    step(1);
    bus.req_valid = '0;
    step(3);
    base = acc_ids.size();
    bus.req_valid = 4'b1010;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step(1);
      if (acc_ids.size() >= base + 3) got = 1'b1;
    end
    bus.req_valid = '0;
    chk("ptr_timeout", 64'(got), 64'(1));
    if (got) begin
      chk("ptr_first", 64'(acc_ids[base]), 64'(3));
      chk("ptr_second", 64'(acc_ids[base + 1]), 64'(1));
      chk("ptr_third", 64'(acc_ids[base + 2]), 64'(3));
    end
    step(4);

    // Asynchronous reset with both stages full
    bus.resp_ready = 1'b0;
    bus.req_valid  = '1;
    step(4);
    chk("full_busy", 64'(busy), 64'(1));
    chk("full_resp_valid", 64'(bus.resp_valid), 64'(1));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_result", 64'(bus.resp_result), 64'(0));
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    step(2);
    rst = 1'b0;
    base = acc_ids.size();
    bus.req_valid = 4'b0011;
    step(1);
    bus.req_valid = '0;
    chk("arst_accepts", 64'(acc_ids.size() - base), 64'(1));
    if (acc_ids.size() > base) chk("arst_first_grant", 64'(acc_ids[base]), 64'(0));
    step(4);
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    chk("final_idle", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
